// File: rtl/add_full.sv
// Registered ripple-carry full adder, 1-cycle latency with valid strobe.
// Optional signed-overflow output enabled by defining ADD_FULL_OVF_EN.
module add_full #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef ADD_FULL_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    // Carry chain evaluated bit by bit; c[i+1] depends on c[i] computed just before.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= s;
                cout_q <= c[WIDTH];
            end
        end
    end

`ifdef ADD_FULL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= c[WIDTH] ^ c[WIDTH-1];
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_full.sv
// Scoreboard bench for add_full: a 1-bit and an 8-bit instance, directed vectors.
// Covers the ovf output as well when built with ADD_FULL_OVF_EN.
module tb_add_full;

    typedef struct packed {
        logic [8:0] res;
        logic       ovf;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid1, in_valid8;
    logic [0:0] a1, b1;
    logic       cin1, cin8;
    logic [7:0] a8, b8;
    logic [0:0] sum1;
    logic [7:0] sum8;
    logic       cout1, cout8, out_valid1, out_valid8;
`ifdef ADD_FULL_OVF_EN
    logic       ovf1, ovf8;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] q1[$];
    exp8_t      q8[$];

    always #5 clk = ~clk;

    add_full #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sum       (sum1),
        .cout      (cout1),
`ifdef ADD_FULL_OVF_EN
        .ovf       (ovf1),
`endif
        .out_valid (out_valid1)
    );

    add_full #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sum       (sum8),
        .cout      (cout8),
`ifdef ADD_FULL_OVF_EN
        .ovf       (ovf8),
`endif
        .out_valid (out_valid8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c,
                          input logic [1:0] exp);
        in_valid1 = v;
        a1        = a;
        b1        = b;
        cin1      = c;
        if (v && rst_n) q1.push_back(exp);
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] exp, input logic ovf);
        exp8_t e;
        in_valid8 = v;
        a8        = a;
        b8        = b;
        cin8      = c;
        e.res     = exp;
        e.ovf     = ovf;
        if (v && rst_n) q8.push_back(e);
    endtask

    // Monitors: pop and compare whenever a DUT presents a fresh result.
    always @(negedge clk) begin
        if (out_valid1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [1:0] e;
                e = q1.pop_front();
                chk("w1_result", {30'd0, cout1, sum1}, {30'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                chk("w8_result", {23'd0, cout8, sum8}, {23'd0, e.res});
`ifdef ADD_FULL_OVF_EN
                chk("w8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // (a,b,cin) -> {cout,sum}, hand-computed truth table.
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst_n = 1'b0;
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
        step();
        step();
        chk("rst_sum1", {31'd0, sum1}, 32'd0);
        chk("rst_cout1", {31'd0, cout1}, 32'd0);
        chk("rst_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_sum8", {24'd0, sum8}, 32'd0);
        chk("rst_cout8", {31'd0, cout8}, 32'd0);
        chk("rst_valid8", {31'd0, out_valid8}, 32'd0);
`ifdef ADD_FULL_OVF_EN
        chk("rst_ovf8", {31'd0, ovf8}, 32'd0);
`endif

        rst_n = 1'b1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            drive1(1'b1, v[2], v[1], v[0], tt[i]);
            step();
        end

        // Hold on the 1-bit cell.
        drive1(1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        step();
        drive1(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
        step();
        chk("hold_valid1", {31'd0, out_valid1}, 32'd0);
        chk("hold_sum1", {31'd0, sum1}, 32'd1);
        chk("hold_cout1", {31'd0, cout1}, 32'd0);

        // 8-bit vectors, back to back.
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0); step();
        drive8(1'b1, 8'h0F, 8'h01, 1'b0, 9'h010, 1'b0); step();
        drive8(1'b1, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1); step();
        drive8(1'b1, 8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1); step();
        drive8(1'b1, 8'h01, 8'h01, 1'b0, 9'h002, 1'b0); step();
        drive8(1'b1, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0); step();
        drive8(1'b1, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1); step();
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0); step();
        chk("hold_valid8", {31'd0, out_valid8}, 32'd0);
        chk("hold_sum8", {24'd0, sum8}, 32'h80);
        chk("hold_cout8", {31'd0, cout8}, 32'd0);
`ifdef ADD_FULL_OVF_EN
        chk("hold_ovf8", {31'd0, ovf8}, 32'd1);
`endif

        // Reset mid-stream with in_valid held high.
        drive8(1'b1, 8'h0F, 8'h01, 1'b0, 9'h010, 1'b0); step();
        rst_n = 1'b0;
        drive8(1'b1, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1); step();
        chk("mid_rst_sum8", {24'd0, sum8}, 32'd0);
        chk("mid_rst_cout8", {31'd0, cout8}, 32'd0);
        chk("mid_rst_valid8", {31'd0, out_valid8}, 32'd0);
        rst_n = 1'b1;
        drive8(1'b1, 8'h01, 8'h01, 1'b0, 9'h002, 1'b0); step();
        chk("resume_valid8", {31'd0, out_valid8}, 32'd1);
        drive8(1'b1, 8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1); step();
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0); step();
        step();
        step();

        chk("q1_drained", q1.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
